// File: rtl/fifo_pkg.sv
// fifo_pkg: shared definitions for the single- and dual-clock FIFO family.
//   - fifo_addr_width / fifo_cnt_width: pointer and occupancy widths for any depth >= 1.
//   - FIFO_MODE_STD / FIFO_MODE_FWFT: read-mode selector values for the FWFT parameter.
//   - fifo_flags_t: registered status flags and their reset value.
package fifo_pkg;

  localparam int unsigned FIFO_MODE_STD  = 0;
  localparam int unsigned FIFO_MODE_FWFT = 1;

  // Pointer width; a depth of 1 still needs a 1-bit address to keep ports legal.
  function automatic int unsigned fifo_addr_width(int unsigned depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

  // Occupancy width; must represent 0..depth inclusive, so depth=2^n needs n+1 bits.
  function automatic int unsigned fifo_cnt_width(int unsigned depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

  typedef struct packed {
    logic full;
    logic empty;
    logic afull;
    logic aempty;
  } fifo_flags_t;

  localparam fifo_flags_t FifoFlagsRst = '{full: 1'b0, empty: 1'b1, afull: 1'b0, aempty: 1'b1};

endpackage

// File: rtl/dualport_ram_sync.sv
// dualport_ram_sync: simple dual-port RAM, single clock, registered read.
//   clk_i           : clock, all ports act on its rising edge
//   we_i/waddr_i/wdata_i : write port
//   re_i/raddr_i    : read request; rdata_o updates on the edge re_i is sampled high
//   rdata_o         : read register, holds its value while re_i is low
// Storage and read register carry no reset. A same-address read and write returns old data.
module dualport_ram_sync
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 4,
  parameter int unsigned DEPTH      = 16,
  localparam int unsigned ADDR_WIDTH = fifo_addr_width(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sync_fifo_fwft.sv
// sync_fifo_fwft: single-clock FIFO with arbitrary depth and standard or FWFT read mode.
//   clk_i, rst_i        : clock; asynchronous active-high reset
//   wr_en_i, wr_data_i  : write request and data (ignored while full)
//   rd_en_i             : read request (FWFT: acknowledge/pop of the presented word)
//   rd_data_o, rd_valid_o : read data and its valid qualifier
//   full_o, empty_o, afull_o, aempty_o : registered status flags
//   count_o             : words held (FWFT: includes the word in the output register)
//   overflow_o, underflow_o : sticky error flags, cleared only by reset
// Standard mode: an accepted read loads the RAM read register; data valid the next cycle.
// FWFT mode: the RAM read register acts as a one-entry prefetch stage qualified by ov_q.
module sync_fifo_fwft
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 4,
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter int unsigned FIFO_AFULL  = FIFO_DEPTH - 1,
  parameter int unsigned FIFO_AEMPTY = 1,
  parameter int unsigned FWFT        = FIFO_MODE_STD,
  localparam int unsigned CNT_WIDTH  = fifo_cnt_width(FIFO_DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wr_en_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  rd_en_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  rd_valid_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic                  afull_o,
  output logic                  aempty_o,
  output logic [CNT_WIDTH-1:0]  count_o,
  output logic                  overflow_o,
  output logic                  underflow_o
);

  localparam int unsigned AddrWidth = fifo_addr_width(FIFO_DEPTH);
  localparam logic [AddrWidth-1:0] LastAddr = AddrWidth'(FIFO_DEPTH - 1);
  localparam logic [CNT_WIDTH-1:0] DepthCnt = CNT_WIDTH'(FIFO_DEPTH);

  // Wrap by explicit compare so non-power-of-two depths work.
  function automatic logic [AddrWidth-1:0] ptr_inc(logic [AddrWidth-1:0] ptr);
    return (ptr == LastAddr) ? '0 : ptr + AddrWidth'(1);
  endfunction

  logic [AddrWidth-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AddrWidth-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_WIDTH-1:0]  count_q, count_d;
  fifo_flags_t           flags_q, flags_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  rd_seen_q, rd_seen_d;

  logic                  wr_vld;
  logic                  rd_vld;
  logic                  ram_re;
  logic                  empty_nxt;
  logic [DATA_WIDTH-1:0] ram_rdata;

  // Requests qualify only against registered flags: no combinational path rd_en->full.
  assign wr_vld = wr_en_i & ~flags_q.full;
  assign rd_vld = rd_en_i & ~flags_q.empty;

  dualport_ram_sync #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (FIFO_DEPTH)
  ) u_ram (
    .clk_i  (clk_i),
    .we_i   (wr_vld),
    .waddr_i(wr_ptr_q),
    .wdata_i(wr_data_i),
    .re_i   (ram_re),
    .raddr_i(rd_ptr_q),
    .rdata_o(ram_rdata)
  );

  if (FWFT != FIFO_MODE_STD) begin : g_fwft
    logic ov_q, ov_d;
    logic ram_has_data;

    // count_q includes the output register, so RAM words = count_q - ov_q.
    assign ram_has_data = (count_q != CNT_WIDTH'(ov_q));
    // Refill when the stage is empty or being consumed this cycle: no bubble.
    assign ram_re       = ram_has_data & (~ov_q | rd_vld);
    assign ov_d         = ram_re | (ov_q & ~rd_vld);
    assign empty_nxt    = ~ov_d;
    assign rd_valid_o   = ov_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        ov_q <= 1'b0;
      end else begin
        ov_q <= ov_d;
      end
    end
  end else begin : g_std
    logic rd_valid_q;

    assign ram_re     = rd_vld;
    assign empty_nxt  = (count_d == '0);
    assign rd_valid_o = rd_valid_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        rd_valid_q <= 1'b0;
      end else begin
        rd_valid_q <= rd_vld;
      end
    end
  end

  always_comb begin
    wr_ptr_d = wr_vld ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = ram_re ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    // In FWFT the counted population leaves at consumption of the output register,
    // in standard mode at the RAM read; both coincide with rd_vld.
    count_d  = count_q + CNT_WIDTH'(wr_vld) - CNT_WIDTH'(rd_vld);

    flags_d.full   = (count_d == DepthCnt);
    flags_d.empty  = empty_nxt;
    flags_d.afull  = (32'(count_d) >= FIFO_AFULL);
    flags_d.aempty = (32'(count_d) <= FIFO_AEMPTY);

    overflow_d  = overflow_q | (wr_en_i & flags_q.full);
    underflow_d = underflow_q | (rd_en_i & flags_q.empty);
    rd_seen_d   = rd_seen_q | ram_re;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      flags_q     <= FifoFlagsRst;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      rd_seen_q   <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      flags_q     <= flags_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      rd_seen_q   <= rd_seen_d;
    end
  end

  // The RAM read register has no reset; mask it until the first read since reset.
  assign rd_data_o   = rd_seen_q ? ram_rdata : '0;
  assign full_o      = flags_q.full;
  assign empty_o     = flags_q.empty;
  assign afull_o     = flags_q.afull;
  assign aempty_o    = flags_q.aempty;
  assign count_o     = count_q;
  assign overflow_o  = overflow_q;
  assign underflow_o = underflow_q;

endmodule

// File: tb/tb_sync_fifo_fwft.sv
// Three FIFOs (std depth 16, std depth 5, FWFT depth 8) driven by shared stimulus.
// Reference model: per-instance queue of words tagged with the edge they were written;
// in FWFT a head word is presentable once it has been stored for at least one full edge.
module tb_sync_fifo_fwft;

  localparam int NI = 3;
  localparam int DEP [NI] = '{16, 5, 8};
  localparam bit FW  [NI] = '{1'b0, 1'b0, 1'b1};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic wr_en = 1'b0;
  logic rd_en = 1'b0;
  logic [3:0] wr_data = '0;

  logic [3:0]    rd_data [NI];
  logic [NI-1:0] rd_valid, full, empty, afull, aempty, ovf, udf;
  logic [4:0]    count_a;
  logic [2:0]    count_b;
  logic [3:0]    count_c;

  always #5 clk = ~clk;

  sync_fifo_fwft #(.DATA_WIDTH(4), .FIFO_DEPTH(16), .FWFT(0)) u_std16 (
    .clk_i(clk), .rst_i(rst), .wr_en_i(wr_en), .wr_data_i(wr_data), .rd_en_i(rd_en),
    .rd_data_o(rd_data[0]), .rd_valid_o(rd_valid[0]), .full_o(full[0]), .empty_o(empty[0]),
    .afull_o(afull[0]), .aempty_o(aempty[0]), .count_o(count_a), .overflow_o(ovf[0]),
    .underflow_o(udf[0])
  );

  sync_fifo_fwft #(.DATA_WIDTH(4), .FIFO_DEPTH(5), .FWFT(0)) u_std5 (
    .clk_i(clk), .rst_i(rst), .wr_en_i(wr_en), .wr_data_i(wr_data), .rd_en_i(rd_en),
    .rd_data_o(rd_data[1]), .rd_valid_o(rd_valid[1]), .full_o(full[1]), .empty_o(empty[1]),
    .afull_o(afull[1]), .aempty_o(aempty[1]), .count_o(count_b), .overflow_o(ovf[1]),
    .underflow_o(udf[1])
  );

  sync_fifo_fwft #(.DATA_WIDTH(4), .FIFO_DEPTH(8), .FWFT(1)) u_fwft8 (
    .clk_i(clk), .rst_i(rst), .wr_en_i(wr_en), .wr_data_i(wr_data), .rd_en_i(rd_en),
    .rd_data_o(rd_data[2]), .rd_valid_o(rd_valid[2]), .full_o(full[2]), .empty_o(empty[2]),
    .afull_o(afull[2]), .aempty_o(aempty[2]), .count_o(count_c), .overflow_o(ovf[2]),
    .underflow_o(udf[2])
  );

  typedef struct {
    logic [3:0] d;
    int         w;
  } word_t;

  word_t      mq [NI][$];
  logic [3:0] sb [NI][$];
  bit         m_ovf [NI];
  bit         m_udf [NI];
  bit         m_rdv [NI];
  int         ecount = 0;
  int         vectors = 0;
  int         miscompares = 0;
  bit         mon_en = 1'b0;

  function automatic int dut_count(int i);
    case (i)
      0:       return int'(count_a);
      1:       return int'(count_b);
      default: return int'(count_c);
    endcase
  endfunction

  function automatic bit head_visible(int i);
    if (mq[i].size() == 0) return 1'b0;
    if (!FW[i]) return 1'b1;
    return mq[i][0].w <= ecount - 1;
  endfunction

  task automatic chk(string name, int i, int act, int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s u%0d @%0t: got %0d, want %0d", name, i, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      mq[i].delete();
      sb[i].delete();
      m_ovf[i] = 1'b0;
      m_udf[i] = 1'b0;
      m_rdv[i] = 1'b0;
    end
  endtask

  // Called right after each rising edge; inputs still hold their pre-edge values.
  task automatic model_edge();
    word_t wd;
    if (rst) begin
      model_reset();
    end else begin
      for (int i = 0; i < NI; i++) begin
        bit vis, is_full, wacc, racc;
        vis     = head_visible(i);
        is_full = (mq[i].size() == DEP[i]);
        wacc    = wr_en && !is_full;
        racc    = rd_en && vis;
        if (wr_en && is_full) m_ovf[i] = 1'b1;
        if (rd_en && !vis) m_udf[i] = 1'b1;
        if (racc) void'(mq[i].pop_front());
        if (wacc) begin
          wd.d = wr_data;
          wd.w = ecount + 1;
          mq[i].push_back(wd);
          sb[i].push_back(wr_data);
        end
        m_rdv[i] = racc;
      end
    end
    ecount++;
  endtask

  task automatic cycle(bit w, logic [3:0] d, bit r);
    wr_en   = w;
    wr_data = d;
    rd_en   = r;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic check_reset_outputs(string tag);
    for (int i = 0; i < NI; i++) begin
      chk({tag, "_count"}, i, dut_count(i), 0);
      chk({tag, "_full"}, i, int'(full[i]), 0);
      chk({tag, "_empty"}, i, int'(empty[i]), 1);
      chk({tag, "_afull"}, i, int'(afull[i]), 0);
      chk({tag, "_aempty"}, i, int'(aempty[i]), 1);
      chk({tag, "_overflow"}, i, int'(ovf[i]), 0);
      chk({tag, "_underflow"}, i, int'(udf[i]), 0);
      chk({tag, "_rd_valid"}, i, int'(rd_valid[i]), 0);
      chk({tag, "_rd_data"}, i, int'(rd_data[i]), 0);
    end
  endtask

  // Monitor: status vs model every cycle; data popped from the scoreboard as presented.
  always @(negedge clk) begin
    if (mon_en) begin
      for (int i = 0; i < NI; i++) begin
        int sz;
        bit vis;
        sz  = mq[i].size();
        vis = head_visible(i);
        chk("count", i, dut_count(i), sz);
        chk("full", i, int'(full[i]), int'(sz == DEP[i]));
        chk("empty", i, int'(empty[i]), int'(!vis));
        chk("afull", i, int'(afull[i]), int'(sz >= DEP[i] - 1));
        chk("aempty", i, int'(aempty[i]), int'(sz <= 1));
        chk("overflow", i, int'(ovf[i]), int'(m_ovf[i]));
        chk("underflow", i, int'(udf[i]), int'(m_udf[i]));
        chk("rd_valid", i, int'(rd_valid[i]), FW[i] ? int'(vis) : int'(m_rdv[i]));
        if (rd_valid[i]) begin
          chk("sb_has_word", i, int'(sb[i].size() > 0), 1);
          if (sb[i].size() > 0) begin
            chk("rd_data", i, int'(rd_data[i]), int'(sb[i][0]));
            if (!FW[i] || rd_en) void'(sb[i].pop_front());
          end
        end
      end
    end
  end

  initial begin
    int pw, pr;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    rst    = 1'b0;
    mon_en = 1'b1;

    // Read of an empty FIFO right after reset.
    cycle(1'b0, 4'h0, 1'b1);
    cycle(1'b0, 4'h0, 1'b0);

    // Fill past capacity, then drain.
    for (int k = 0; k < 17; k++) cycle(1'b1, 4'(k), 1'b0);
    for (int k = 0; k < 18; k++) cycle(1'b0, 4'h0, 1'b1);

    // Write-5/read-5 rounds: exercises pointer wrap on the depth-5 instance.
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 5; k++) cycle(1'b1, 4'(r * 5 + k), 1'b0);
      for (int k = 0; k < 5; k++) cycle(1'b0, 4'h0, 1'b1);
    end
    for (int k = 0; k < 10; k++) cycle(1'b0, 4'h0, 1'b1);

    // Single write into an empty FIFO, observe latency, then pop.
    cycle(1'b1, 4'hA, 1'b0);
    cycle(1'b0, 4'h0, 1'b0);
    cycle(1'b0, 4'h0, 1'b0);
    cycle(1'b0, 4'h0, 1'b1);
    cycle(1'b0, 4'h0, 1'b0);
    cycle(1'b0, 4'h0, 1'b0);

    // Hold count at 7 with simultaneous traffic.
    for (int k = 0; k < 7; k++) cycle(1'b1, 4'($urandom), 1'b0);
    cycle(1'b0, 4'h0, 1'b0);
    for (int k = 0; k < 50; k++) cycle(1'b1, 4'($urandom), 1'b1);
    for (int k = 0; k < 20; k++) cycle(1'b0, 4'h0, 1'b1);

    // Simultaneous write+read while full: write rejected.
    for (int k = 0; k < 16; k++) cycle(1'b1, 4'($urandom), 1'b0);
    cycle(1'b1, 4'hF, 1'b1);
    for (int k = 0; k < 20; k++) cycle(1'b0, 4'h0, 1'b1);

    // Randomised traffic with varying write/read pressure.
    for (int seg = 0; seg < 20; seg++) begin
      pw = int'($urandom_range(90, 10));
      pr = int'($urandom_range(90, 10));
      for (int k = 0; k < 80; k++) begin
        cycle(int'($urandom_range(99, 0)) < pw, 4'($urandom), int'($urandom_range(99, 0)) < pr);
      end
    end

    // Clean reset, then count up to 9 and reset asynchronously mid-cycle with wr_en high.
    rst = 1'b1;
    model_reset();
    #1;
    check_reset_outputs("rst2");
    cycle(1'b0, 4'h0, 1'b0);
    rst = 1'b0;
    for (int k = 0; k < 9; k++) cycle(1'b1, 4'(k + 3), 1'b0);
    wr_en   = 1'b1;
    wr_data = 4'hC;
    rd_en   = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    model_reset();
    @(posedge clk);
    model_edge();
    #1;
    rst = 1'b0;
    cycle(1'b1, 4'h5, 1'b0);
    cycle(1'b0, 4'h0, 1'b0);
    cycle(1'b0, 4'h0, 1'b0);
    cycle(1'b0, 4'h0, 1'b1);
    cycle(1'b0, 4'h0, 1'b0);
    cycle(1'b0, 4'h0, 1'b0);

    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
